// File: rtl/html_char_stream.sv
// Streams a zero-terminated HTML document from a synchronous ROM to the parser,
// one whitespace-normalised character at a time, holding each one while the parser pauses.
module html_char_stream #(
    parameter int ADDR_WIDTH = 10,
    parameter int CHAR_WIDTH = 8,
    parameter int DOC_LENGTH = 1024
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  pause,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [CHAR_WIDTH-1:0] mem_data,
    output logic [CHAR_WIDTH-1:0] char,
    output logic                  char_valid,
    output logic                  parser_enable,
    output logic                  busy,
    output logic                  done
);

    // One extra bit so DOC_LENGTH == 2**ADDR_WIDTH is reachable without wrapping.
    localparam logic [ADDR_WIDTH:0]   DOC_END  = (ADDR_WIDTH+1)'(DOC_LENGTH);
    localparam logic [ADDR_WIDTH:0]   ADDR_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [CHAR_WIDTH-1:0] CH_NUL   = '0;
    localparam logic [CHAR_WIDTH-1:0] CH_SPACE = CHAR_WIDTH'(32'h20);
    localparam logic [CHAR_WIDTH-1:0] CH_CR    = CHAR_WIDTH'(32'h0D);
    localparam logic [CHAR_WIDTH-1:0] CH_LF    = CHAR_WIDTH'(32'h0A);
    localparam logic [CHAR_WIDTH-1:0] CH_TAB   = CHAR_WIDTH'(32'h09);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_CHECK,
        ST_PRESENT,
        ST_DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [CHAR_WIDTH-1:0] char_reg, char_next;
    logic                  valid_reg, valid_next;
    logic                  enable_reg, enable_next;
    logic                  done_reg, done_next;
    logic                  collapse_reg, collapse_next;
    logic                  dwell_reg, dwell_next;

    logic [ADDR_WIDTH:0]   addr_inc;
    logic                  last_addr;
    logic                  is_ws;
    logic [CHAR_WIDTH-1:0] char_norm;

    assign addr_inc  = {1'b0, addr_reg} + ADDR_ONE;
    assign last_addr = (addr_inc == DOC_END);
    assign is_ws     = (char_reg == CH_CR) || (char_reg == CH_LF) || (char_reg == CH_TAB);
    assign char_norm = is_ws ? CH_SPACE : char_reg;

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        char_next     = char_reg;
        valid_next    = valid_reg;
        enable_next   = enable_reg;
        done_next     = done_reg;
        collapse_next = collapse_reg;
        dwell_next    = dwell_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next    = ST_FETCH;
                    addr_next     = '0;
                    enable_next   = 1'b1;
                    done_next     = 1'b0;
                    collapse_next = 1'b0;
                end
            end

            ST_FETCH: state_next = ST_WAIT;

            ST_WAIT: begin
                char_next  = mem_data;
                state_next = ST_CHECK;
            end

            ST_CHECK: begin
                if (char_reg == CH_NUL) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else if ((char_norm == CH_SPACE) && collapse_reg) begin
                    // Redundant whitespace: move on without presenting it.
                    if (last_addr) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                        char_next  = CH_NUL;
                    end else begin
                        state_next = ST_FETCH;
                        addr_next  = addr_inc[ADDR_WIDTH-1:0];
                    end
                end else begin
                    state_next    = ST_PRESENT;
                    char_next     = char_norm;
                    valid_next    = 1'b1;
                    collapse_next = (char_norm == CH_SPACE);
                    dwell_next    = 1'b0;
                end
            end

            ST_PRESENT: begin
                // First cycle is a forced dwell so the parser can raise pause in time.
                if (!dwell_reg) begin
                    dwell_next = 1'b1;
                end else if (!pause) begin
                    valid_next = 1'b0;
                    if (last_addr) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                        char_next  = CH_NUL;
                    end else begin
                        state_next = ST_FETCH;
                        addr_next  = addr_inc[ADDR_WIDTH-1:0];
                    end
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            char_reg     <= '0;
            valid_reg    <= 1'b0;
            enable_reg   <= 1'b0;
            done_reg     <= 1'b0;
            collapse_reg <= 1'b0;
            dwell_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            char_reg     <= char_next;
            valid_reg    <= valid_next;
            enable_reg   <= enable_next;
            done_reg     <= done_next;
            collapse_reg <= collapse_next;
            dwell_reg    <= dwell_next;
        end
    end

    assign mem_addr      = addr_reg;
    assign char          = char_reg;
    assign char_valid    = valid_reg;
    assign parser_enable = enable_reg;
    assign done          = done_reg;
    assign busy          = (state_reg != ST_IDLE) && (state_reg != ST_DONE);

endmodule

// File: tb/tb_html_char_stream.sv
// Self-checking bench for html_char_stream: hand tables, corner sequences and random
// documents compared against a document-walk reference model.
module tb_html_char_stream;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       start_s = 1'b0;

    logic [9:0] mem_addr;
    logic [7:0] mem_data, char;
    logic       char_valid, parser_enable, busy, done;

    logic [9:0] mem_addr_s;
    logic [7:0] mem_data_s, char_s;
    logic       valid_s, enable_s, busy_s, done_s;

    logic [1:0] mem_addr_t;
    logic [7:0] mem_data_t, char_t;
    logic       valid_t, enable_t, busy_t, done_t;

    logic [7:0] rom   [0:1023];
    logic [7:0] rom_s [0:1023];
    logic [7:0] rom_t [0:3];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        mem_data   <= rom[mem_addr];
        mem_data_s <= rom_s[mem_addr_s];
        mem_data_t <= rom_t[mem_addr_t];
    end

    html_char_stream #(.ADDR_WIDTH(10), .CHAR_WIDTH(8), .DOC_LENGTH(1024)) dut (
        .clock(clock), .resetn(resetn), .start(start), .pause(pause),
        .mem_addr(mem_addr), .mem_data(mem_data), .char(char), .char_valid(char_valid),
        .parser_enable(parser_enable), .busy(busy), .done(done)
    );

    html_char_stream #(.ADDR_WIDTH(10), .CHAR_WIDTH(8), .DOC_LENGTH(4)) dut_s (
        .clock(clock), .resetn(resetn), .start(start_s), .pause(1'b0),
        .mem_addr(mem_addr_s), .mem_data(mem_data_s), .char(char_s), .char_valid(valid_s),
        .parser_enable(enable_s), .busy(busy_s), .done(done_s)
    );

    html_char_stream #(.ADDR_WIDTH(2), .CHAR_WIDTH(8), .DOC_LENGTH(4)) dut_t (
        .clock(clock), .resetn(resetn), .start(start_s), .pause(1'b0),
        .mem_addr(mem_addr_t), .mem_data(mem_data_t), .char(char_t), .char_valid(valid_t),
        .parser_enable(enable_t), .busy(busy_t), .done(done_t)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$], act_q[$];
    int         exp_t[$], act_t[$];
    int         exp_done, act_done;
    int         stable_err;
    int         max_addr;

    typedef struct {
        string doc;
        string exp;
        int    done_t;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic load_doc(input string s);
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) rom[i] = s[i];
    endtask

    task automatic load_random(input int len);
        logic [7:0] alpha [12];
        alpha = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h3C, 8'h3E, 8'h2F, 8'h20, 8'h20, 8'h0A, 8'h09, 8'h0D};
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
        for (int i = 0; i < len; i++) rom[i] = alpha[$urandom_range(0, 11)];
    endtask

    // Walk the document as the parser should see it: stop at NUL or DOC_LENGTH,
    // fold CR/LF/TAB to space, drop spaces that follow a presented space.
    function automatic void model(input int doc_len);
        logic [7:0] c;
        bit         coll;
        int         t;
        coll = 1'b0;
        t = 0;
        exp_q.delete();
        exp_t.delete();
        exp_done = -1;
        for (int a = 0; a < doc_len; a++) begin
            c = rom[a];
            if (c == 8'h00) begin
                exp_done = t + 3;
                return;
            end
            if (c inside {8'h0D, 8'h0A, 8'h09}) c = 8'h20;
            if (c == 8'h20 && coll) begin
                t += 3;
            end else begin
                exp_q.push_back(c);
                exp_t.push_back(t + 3);
                coll = (c == 8'h20);
                t += 5;
            end
        end
        exp_done = t;
    endfunction

    // Pulse start, then record every presentation (char, edge index after start) until done.
    task automatic run_stream(input int pause_mode, input int mid_start, input int budget);
        logic       prev_valid;
        logic [7:0] prev_char;
        act_q.delete();
        act_t.delete();
        act_done   = -1;
        stable_err = 0;
        max_addr   = 0;
        prev_valid = 1'b0;
        prev_char  = 8'h00;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clock);
            #1;
            if (char_valid && !prev_valid) begin
                act_q.push_back(char);
                act_t.push_back(k);
            end
            if (char_valid && prev_valid && char != prev_char) stable_err++;
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            if (done) begin
                act_done = k;
                break;
            end
            prev_valid = char_valid;
            prev_char  = char;
            start = (k + 1 == mid_start);
            if (pause_mode != 0) pause = ($urandom_range(0, 2) == 0);
        end
        start = 1'b0;
        pause = 1'b0;
        $display("run: %0d chars presented, done at cycle %0d, max addr %0d",
                 act_q.size(), act_done, max_addr);
    endtask

    task automatic compare_run(input string tag, input bit timing);
        int n;
        check({tag, " count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s char%0d", tag, i), act_q[i], exp_q[i]);
            if (timing) check($sformatf("%s time%0d", tag, i), act_t[i], exp_t[i]);
        end
        if (timing) check({tag, " done cycle"}, act_done, exp_done);
        else check({tag, " done seen"}, act_done > 0, 1);
        check({tag, " stable"}, stable_err, 0);
    endtask

    task automatic check_string(input string tag, input string s);
        int n;
        check({tag, " length"}, act_q.size(), s.len());
        n = (act_q.size() < s.len()) ? act_q.size() : s.len();
        for (int i = 0; i < n; i++) check($sformatf("%s char%0d", tag, i), act_q[i], s[i]);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget && !done; k++) begin
            @(posedge clock);
            #1;
        end
        check({tag, " done reached"}, done, 1);
    endtask

    initial begin
        int k;
        int hold_bad;
        int cnt_s, cnt_t, ds_k, dt_k, max_s;
        logic pv_s, pv_t;

        vecs[0] = '{"<p>Hi</p>", "<p>Hi</p>", 48};
        vecs[1] = '{"a \n\t b", "a b", 27};
        vecs[2] = '{"  x", " x", 16};
        vecs[3] = '{"", "", 3};
        vecs[4] = '{"\015\nA\tB", " A B", 26};

        load_doc("");
        for (int i = 0; i < 1024; i++) rom_s[i] = (i < 8) ? 8'h61 + 8'(i) : 8'h00;
        for (int i = 0; i < 4; i++) rom_t[i] = 8'h61 + 8'(i);

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset mem_addr", mem_addr, 0);
        check("reset char", char, 0);
        check("reset char_valid", char_valid, 0);
        check("reset parser_enable", parser_enable, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        resetn = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("idle without start busy", busy, 0);
        check("idle without start enable", parser_enable, 0);

        // Table-driven documents, pause held low
        for (int i = 0; i < 5; i++) begin
            load_doc(vecs[i].doc);
            model(1024);
            run_stream(0, -1, 600);
            compare_run($sformatf("vec%0d", i), 1'b1);
            check_string($sformatf("vec%0d hand", i), vecs[i].exp);
            check($sformatf("vec%0d hand done", i), act_done, vecs[i].done_t);
        end

        // Done is held; start in DONE restarts on the same edge
        repeat (3) @(posedge clock);
        #1;
        check("done held", done, 1);
        check("done busy", busy, 0);
        check("done char", char, 0);
        check("done char_valid", char_valid, 0);
        check("done parser_enable", parser_enable, 1);
        load_doc("ok");
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check("restart done cleared", done, 0);
        check("restart busy", busy, 1);
        check("restart mem_addr", mem_addr, 0);
        wait_done("restart", 100);

        // Pause held high for 20 cycles from the 2nd PRESENT cycle
        load_doc("xy");
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        k = 0;
        while (!char_valid && k < 20) begin
            @(posedge clock);
            #1 k++;
        end
        check("hold first rise", k, 3);
        @(posedge clock);
        #1 pause = 1'b1;
        hold_bad = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (char !== 8'h78 || char_valid !== 1'b1) hold_bad++;
        end
        pause = 1'b0;
        check("hold stable cycles", hold_bad, 0);
        @(posedge clock);
        #1;
        check("hold release valid", char_valid, 0);
        check("hold release fetch addr", mem_addr, 1);
        check("hold release busy", busy, 1);
        wait_done("hold", 100);

        // Reset during PRESENT with pause high, then leading space must present
        load_doc(" q");
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        #1 pause = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("pre-reset char_valid", char_valid, 1);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        check("midreset mem_addr", mem_addr, 0);
        check("midreset char", char, 0);
        check("midreset char_valid", char_valid, 0);
        check("midreset parser_enable", parser_enable, 0);
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        resetn = 1'b1;
        pause = 1'b0;
        model(1024);
        run_stream(0, -1, 200);
        compare_run("post-reset", 1'b1);
        check_string("post-reset hand", " q");

        // start pulsed mid-stream is ignored
        load_doc("abcdef");
        model(1024);
        run_stream(0, 7, 400);
        compare_run("midstart7", 1'b1);
        run_stream(0, 19, 400);
        compare_run("midstart19", 1'b1);

        // Random documents; even runs check timing, odd runs use random pause
        for (int r = 0; r < 8; r++) begin
            load_random($urandom_range(0, 40));
            model(1024);
            run_stream(r % 2, -1, 3000);
            compare_run($sformatf("rand%0d", r), (r % 2) == 0);
        end

        // DOC_LENGTH=4 with no terminator, in a wide and a 2-bit address space
        start_s = 1'b1;
        @(posedge clock);
        #1 start_s = 1'b0;
        cnt_s = 0; cnt_t = 0; ds_k = -1; dt_k = -1; max_s = 0;
        pv_s = 1'b0; pv_t = 1'b0;
        for (int kk = 1; kk <= 60; kk++) begin
            @(posedge clock);
            #1;
            if (valid_s && !pv_s) begin
                check($sformatf("len4 char%0d", cnt_s), char_s, 8'h61 + 8'(cnt_s));
                check($sformatf("len4 time%0d", cnt_s), kk, 3 + 5 * cnt_s);
                cnt_s++;
            end
            if (valid_t && !pv_t) begin
                check($sformatf("aw2 char%0d", cnt_t), char_t, 8'h61 + 8'(cnt_t));
                cnt_t++;
            end
            if (int'(mem_addr_s) > max_s) max_s = int'(mem_addr_s);
            if (done_s && ds_k < 0) ds_k = kk;
            if (done_t && dt_k < 0) dt_k = kk;
            pv_s = valid_s;
            pv_t = valid_t;
        end
        $display("len4: %0d chars, done at %0d; aw2: %0d chars, done at %0d", cnt_s, ds_k, cnt_t, dt_k);
        check("len4 count", cnt_s, 4);
        check("len4 done cycle", ds_k, 20);
        check("len4 max addr", max_s, 3);
        check("aw2 count", cnt_t, 4);
        check("aw2 done cycle", dt_k, 20);
        check("aw2 done held", done_t, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
